// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces three raw coin sensors, classifies
// rising-edge coin events, and queues accepted coins as one-hot codes that
// are handed downstream over a valid/ready handshake.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       coin_sense,
  input  logic             coin_ready,
  output logic [2:0]       coin_code,
  output logic             coin_valid,
  output logic             coin_accept,
  output logic             coin_reject,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned NLINES = 3;
  localparam int unsigned DB_W   = 8;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Synchroniser, debounce and edge-history state
  logic [NLINES-1:0] sync1;
  logic [NLINES-1:0] sync2;
  logic [NLINES-1:0] level;
  logic [NLINES-1:0] level_prev;
  logic [NLINES-1:0] level_nxt;
  logic [DB_W-1:0]   db_cnt     [NLINES];
  logic [DB_W-1:0]   db_cnt_nxt [NLINES];

  // Queue state
  logic [2:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;

  // Classification results for the current cycle
  logic [NLINES-1:0] evt;
  logic              evt_any;
  logic              evt_single;
  logic              q_full;
  logic              pop;
  logic              push;
  logic              refuse;

  // Two-flop synchroniser for the asynchronous sensor lines
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= coin_sense;
      sync2 <= sync1;
    end
  end

  // Debounce next-state: a line flips only after DEBOUNCE_CYCLES disagreeing samples in a row
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < int'(NLINES); i++) begin
      db_cnt_nxt[i] = '0;
      if (sync2[i] != level[i]) begin
        if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_nxt[i]  = sync2[i];
          db_cnt_nxt[i] = '0;
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounce and edge-history registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      level      <= '0;
      level_prev <= '0;
      for (int i = 0; i < int'(NLINES); i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      level      <= level_nxt;
      level_prev <= level;
      for (int i = 0; i < int'(NLINES); i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
    end
  end

  // Head of queue is visible combinationally from registered state
  always_comb begin
    coin_valid = (count != '0);
    coin_code  = coin_valid ? mem[rptr] : 3'b000;
    fifo_count = count;
  end

  // Event classification: only a lone coin on an enabled block with room is queued
  always_comb begin
    evt        = level & ~level_prev;
    evt_any    = (evt != '0);
    evt_single = $onehot(evt);
    q_full     = (count == CNT_W'(FIFO_DEPTH));
    pop        = coin_valid && coin_ready;
    push       = evt_single && enable && (!q_full || pop);
    refuse     = evt_any && !push;
  end

  // Accept/reject pulses, one cycle each and mutually exclusive by construction
  always_ff @(posedge clk) begin
    if (!rst) begin
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      coin_accept <= push;
      coin_reject <= refuse;
    end
  end

  // Circular buffer storage and pointers; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= 3'b000;
      end
    end else begin
      if (push) begin
        mem[wptr] <= evt;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
    end
  end

  // Occupancy tracks push/pop at the same edge; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
